pixel_bus_transmitter: RTL and testbench

Transmit side of the two-byte MCU pixel bus. Accepts 12-bit pixels over a valid/ready handshake, buffers them in a small FIFO, and serializes each pixel as two bytes on an 8-bit bus with a self-generated bus clock and a command/data line. This is exactly the framing the FPGA pixel receiver consumes. Used for pixel readback toward the MCU and as the bus driver in loopback benches. An optional command byte can be inserted between pixels.

---
 rtl/pixel_bus_pkg.sv | 18 +
 rtl/pixel_fifo.sv | 34 +++
 rtl/pixel_bus_transmitter.sv | 97 +++++++++
 tb/tb_pixel_bus_transmitter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_bus_pkg.sv
// pixel_bus_pkg: shared encodings and byte-split constants for the two-byte MCU pixel bus.
package pixel_bus_pkg;
    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_FIRST_LOW   = 3'd1;
    localparam logic [2:0] ST_FIRST_HIGH  = 3'd2;
    localparam logic [2:0] ST_SECOND_LOW  = 3'd3;
    localparam logic [2:0] ST_SECOND_HIGH = 3'd4;
    localparam logic [2:0] ST_CMD_LOW     = 3'd5;
    localparam logic [2:0] ST_CMD_HIGH    = 3'd6;
    localparam logic BUS_SEL_COMMAND = 1'b1;
    localparam logic BUS_SEL_DATA    = 1'b0;
    localparam int HI_MSB   = 11;
    localparam int HI_LSB   = 4;
    localparam int LO_WIDTH = 4;
    function automatic logic is_high(input logic [2:0] s);
        return s == ST_FIRST_HIGH || s == ST_SECOND_HIGH || s == ST_CMD_HIGH;
    endfunction
endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: synchronous FIFO with full/empty flags and asynchronous active-low reset.
module pixel_fifo #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  logic             system_clock,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    // extra pointer bit separates full from empty when the indices match
    assign full = wr_ptr[AW] != rd_ptr[AW] && wr_ptr[AW-1:0] == rd_ptr[AW-1:0];
    assign empty = wr_ptr == rd_ptr;
    assign pop_data = mem[rd_ptr[AW-1:0]];
    always_ff @(posedge system_clock) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
    end
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule

// File: rtl/pixel_bus_transmitter.sv
// pixel_bus_transmitter: serializes 12-bit pixels as two bus bytes with optional command bytes.
// Define PIXEL_BUS_TRANSMITTER_STATS_EN to add the pixel_count output.
module pixel_bus_transmitter
    import pixel_bus_pkg::*;
#(
    parameter int CLOCK_DIVIDER = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        system_clock,
    input  logic        reset_n,
    input  logic [11:0] pixel_data,
    input  logic        pixel_valid,
    output logic        pixel_ready,
    input  logic        command_valid,
    input  logic [7:0]  command_byte,
    output logic        command_ready,
    output logic [7:0]  bus_data,
    output logic        bus_clock,
    output logic        bus_command_data,
`ifdef PIXEL_BUS_TRANSMITTER_STATS_EN
    output logic [15:0] pixel_count,
`endif
    output logic        busy
);
    logic [2:0]          state, next_state;
    logic [3:0]          phase;
    logic                pending;
    logic [7:0]          command_reg;
    logic [LO_WIDTH-1:0] low_nibble;
    logic [11:0]         fifo_data;
    logic                fifo_full, fifo_empty, pop, phase_done, arbitrate;
    logic [7:0]          next_data;
    logic                next_sel;

    pixel_fifo #(.WIDTH(12), .DEPTH(FIFO_DEPTH)) u_fifo (
        .system_clock(system_clock),
        .reset_n(reset_n),
        .push(pixel_valid && pixel_ready),
        .push_data(pixel_data),
        .pop(pop),
        .pop_data(fifo_data),
        .full(fifo_full),
        .empty(fifo_empty)
    );

    assign pixel_ready = reset_n && !fifo_full;
    assign command_ready = !pending;
    assign busy = state != ST_IDLE || !fifo_empty || pending;
    assign phase_done = phase == 4'(CLOCK_DIVIDER - 1);
    assign arbitrate = state == ST_IDLE || (phase_done && (state == ST_SECOND_HIGH || state == ST_CMD_HIGH));
    assign pop = arbitrate && !pending && !fifo_empty;

    always_comb begin
        next_state = state;
        next_data = bus_data;
        next_sel = bus_command_data;
        if (arbitrate) begin
            next_state = pending ? ST_CMD_LOW : pop ? ST_FIRST_LOW : ST_IDLE;
            next_data = pending ? command_reg : pop ? fifo_data[HI_MSB:HI_LSB] : bus_data;
            next_sel = pending ? BUS_SEL_COMMAND : pop ? BUS_SEL_DATA : bus_command_data;
        end else if (phase_done) begin
            // encodings are ordered so every non-arbitrating exit is the next code
            next_state = state + 3'd1;
            next_data = state == ST_FIRST_HIGH ? {{(8-LO_WIDTH){1'b0}}, low_nibble} : bus_data;
        end
    end

    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            phase <= '0;
            pending <= 1'b0;
            command_reg <= '0;
            low_nibble <= '0;
            bus_data <= '0;
            bus_clock <= 1'b0;
            bus_command_data <= BUS_SEL_DATA;
        end else begin
            state <= next_state;
            phase <= next_state != state ? 4'd0 : phase + 4'd1;
            bus_data <= next_data;
            bus_command_data <= next_sel;
            bus_clock <= is_high(next_state);
            if (pop) low_nibble <= fifo_data[LO_WIDTH-1:0];
            if (arbitrate && pending) pending <= 1'b0;
            else if (command_valid && !pending) pending <= 1'b1;
            if (command_valid && !pending) command_reg <= command_byte;
        end
    end

`ifdef PIXEL_BUS_TRANSMITTER_STATS_EN
    always_ff @(posedge system_clock or negedge reset_n) begin
        if (!reset_n) pixel_count <= '0;
        else if (phase_done && state == ST_SECOND_HIGH) pixel_count <= pixel_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_pixel_bus_transmitter.sv
// tb_pixel_bus_transmitter: scoreboard bench; stimulus pushes expected bus bytes, a monitor checks each rising bus_clock.
module tb_pixel_bus_transmitter;
    logic        system_clock;
    logic        reset_n;
    logic [11:0] pixel_data;
    logic        pixel_valid;
    logic        pixel_ready;
    logic        command_valid;
    logic [7:0]  command_byte;
    logic        command_ready;
    logic [7:0]  bus_data;
    logic        bus_clock;
    logic        bus_command_data;
    logic        busy;
`ifdef PIXEL_BUS_TRANSMITTER_STATS_EN
    logic [15:0] pixel_count;
`endif

    typedef struct {
        logic [7:0] data;
        logic       sel;
        int         gap;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   cycle = 0;
    int   ref_cycle = 0;
    logic prev_clk = 1'b0;

    logic [11:0] burst_px [6] = '{12'h1A2, 12'h3B4, 12'h5C6, 12'h7D8, 12'h9E0, 12'hF01};
    logic [7:0]  burst_hi [6] = '{8'h1A, 8'h3B, 8'h5C, 8'h7D, 8'h9E, 8'hF0};
    logic [7:0]  burst_lo [6] = '{8'h02, 8'h04, 8'h06, 8'h08, 8'h00, 8'h01};

    pixel_bus_transmitter #(.CLOCK_DIVIDER(2), .FIFO_DEPTH(4)) dut (
        .system_clock(system_clock),
        .reset_n(reset_n),
        .pixel_data(pixel_data),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .command_valid(command_valid),
        .command_byte(command_byte),
        .command_ready(command_ready),
        .bus_data(bus_data),
        .bus_clock(bus_clock),
        .bus_command_data(bus_command_data),
`ifdef PIXEL_BUS_TRANSMITTER_STATS_EN
        .pixel_count(pixel_count),
`endif
        .busy(busy)
    );

    initial system_clock = 1'b0;
    always #5 system_clock = ~system_clock;
    always @(posedge system_clock) cycle <= cycle + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=0x%0h want=0x%0h t=%0t", name, act, req, $time);
        end
    endfunction

    function automatic void push_exp(input logic [7:0] d, input logic s, input int g);
        exp_t e;
        e.data = d;
        e.sel = s;
        e.gap = g;
        exp_q.push_back(e);
    endfunction

    // gap = cycles since the previous rising bus_clock, or since acceptance for the first byte
    always @(negedge system_clock) begin
        if (bus_clock && !prev_clk) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_byte got=0x%0h sel=%0b t=%0t", bus_data, bus_command_data, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("bus_data", 32'(bus_data), 32'(mon_e.data));
                check("bus_command_data", 32'(bus_command_data), 32'(mon_e.sel));
                check("rise_gap", cycle - ref_cycle, mon_e.gap);
            end
            ref_cycle = cycle;
        end
        prev_clk = bus_clock;
    end

    task automatic wait_drain();
        for (int k = 0; k < 400 && (busy || exp_q.size() != 0); k++) @(negedge system_clock);
        check("drain_timeout", (busy || exp_q.size() != 0) ? 1 : 0, 0);
    endtask

    task automatic send_pixel(input logic [11:0] p, input logic [7:0] hi, input logic [7:0] lo, input bit set_ref);
        pixel_data = p;
        pixel_valid = 1'b1;
        for (int k = 0; k < 100 && !pixel_ready; k++) @(negedge system_clock);
        check("send_ready", 32'(pixel_ready), 1);
        @(posedge system_clock);
        #1;
        pixel_valid = 1'b0;
        if (set_ref) ref_cycle = cycle;
        push_exp(hi, 1'b0, set_ref ? 3 : 4);
        push_exp(lo, 1'b0, 4);
    endtask

    initial begin
        int   i;
        bit   stalled;
        logic accept;
        reset_n = 1'b0;
        pixel_valid = 1'b0;
        pixel_data = '0;
        command_valid = 1'b0;
        command_byte = '0;
        repeat (3) @(negedge system_clock);
        check("reset_bus_data", 32'(bus_data), 0);
        check("reset_bus_clock", 32'(bus_clock), 0);
        check("reset_bus_sel", 32'(bus_command_data), 0);
        check("reset_busy", 32'(busy), 0);
        check("reset_command_ready", 32'(command_ready), 1);
        check("reset_pixel_ready", 32'(pixel_ready), 0);
        reset_n = 1'b1;
        @(negedge system_clock);
        check("release_pixel_ready", 32'(pixel_ready), 1);

        send_pixel(12'hABC, 8'hAB, 8'h0C, 1'b1);
        wait_drain();
        @(negedge system_clock);
        check("idle_hold_data", 32'(bus_data), 32'h0C);
        check("idle_bus_clock", 32'(bus_clock), 0);
        check("idle_busy", 32'(busy), 0);

        i = 0;
        stalled = 1'b0;
        pixel_valid = 1'b1;
        for (int k = 0; k < 200 && i < 6; k++) begin
            pixel_data = burst_px[i];
            accept = pixel_ready;
            @(posedge system_clock);
            #1;
            if (accept) begin
                if (i == 0) ref_cycle = cycle;
                push_exp(burst_hi[i], 1'b0, i == 0 ? 3 : 4);
                push_exp(burst_lo[i], 1'b0, 4);
                i++;
            end else stalled = 1'b1;
        end
        pixel_valid = 1'b0;
        check("burst_accepted", i, 6);
        check("burst_ready_drop", 32'(stalled), 1);
        wait_drain();

        send_pixel(12'h123, 8'h12, 8'h03, 1'b1);
        @(negedge system_clock);
        command_byte = 8'h5A;
        command_valid = 1'b1;
        check("cmd_ready_before", 32'(command_ready), 1);
        @(posedge system_clock);
        #1;
        command_valid = 1'b0;
        push_exp(8'h5A, 1'b1, 4);
        for (int k = 0; k < 50 && !command_ready; k++) begin
            check("cmd_sel_hold", 32'(bus_command_data), 0);
            @(negedge system_clock);
        end
        check("cmd_ready_back", 32'(command_ready), 1);
        check("cmd_low_sel", 32'(bus_command_data), 1);
        check("cmd_low_data", 32'(bus_data), 32'h5A);
        check("cmd_low_clock", 32'(bus_clock), 0);
        wait_drain();

        @(negedge system_clock);
        pixel_data = 12'h456;
        pixel_valid = 1'b1;
        command_byte = 8'hC3;
        command_valid = 1'b1;
        check("prio_pixel_ready", 32'(pixel_ready), 1);
        check("prio_command_ready", 32'(command_ready), 1);
        @(posedge system_clock);
        #1;
        pixel_valid = 1'b0;
        command_valid = 1'b0;
        ref_cycle = cycle;
        push_exp(8'hC3, 1'b1, 3);
        push_exp(8'h45, 1'b0, 4);
        push_exp(8'h06, 1'b0, 4);
        wait_drain();

        @(negedge system_clock);
        pixel_data = 12'h789;
        pixel_valid = 1'b1;
        @(posedge system_clock);
        #1;
        ref_cycle = cycle;
        push_exp(8'h78, 1'b0, 3);
        pixel_data = 12'hAAA;
        @(posedge system_clock);
        #1;
        pixel_valid = 1'b0;
        for (int k = 0; k < 50 && !bus_clock; k++) @(negedge system_clock);
        check("rst_reached_high", 32'(bus_clock), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_bus_clock", 32'(bus_clock), 0);
        check("rst_bus_data", 32'(bus_data), 0);
        check("rst_bus_sel", 32'(bus_command_data), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_pixel_ready", 32'(pixel_ready), 0);
        check("rst_queue", exp_q.size(), 0);
        repeat (2) @(negedge system_clock);
        reset_n = 1'b1;
        @(negedge system_clock);
        check("rst_release_busy", 32'(busy), 0);
        check("rst_release_pixel_ready", 32'(pixel_ready), 1);
        check("rst_release_command_ready", 32'(command_ready), 1);
        repeat (20) @(negedge system_clock);
        check("rst_no_traffic_clock", 32'(bus_clock), 0);
        check("rst_no_traffic_busy", 32'(busy), 0);

        send_pixel(12'h0F0, 8'h0F, 8'h00, 1'b1);
        send_pixel(12'h5A5, 8'h5A, 8'h05, 1'b0);
        send_pixel(12'hFFF, 8'hFF, 8'h0F, 1'b0);
        wait_drain();
`ifdef PIXEL_BUS_TRANSMITTER_STATS_EN
        check("pixel_count", 32'(pixel_count), 3);
`endif
        repeat (5) @(negedge system_clock);
        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog_timeout t=%0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
